// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter sharing one memory request/return channel between icache and dcache.
// Zero-latency return routing; per-requester outstanding credit tracking with a sticky error flag.
module wt_mem_arbiter #(
  parameter int unsigned REQ_W     = 128,
  parameter int unsigned RTRN_W    = 160,
  parameter int unsigned TID_W     = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic              ic_rsp_exp_i,
  input  logic [TID_W-1:0]  ic_tid_i,
  input  logic [REQ_W-1:0]  ic_data_i,
  output logic              ic_ack_o,
  input  logic              dc_req_i,
  input  logic              dc_rsp_exp_i,
  input  logic [TID_W-1:0]  dc_tid_i,
  input  logic [REQ_W-1:0]  dc_data_i,
  output logic              dc_ack_o,
  output logic              mem_req_o,
  output logic              mem_src_o,
  output logic [TID_W-1:0]  mem_tid_o,
  output logic [REQ_W-1:0]  mem_data_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rtrn_vld_i,
  input  logic              mem_rtrn_src_i,
  input  logic [TID_W-1:0]  mem_rtrn_tid_i,
  input  logic [RTRN_W-1:0] mem_rtrn_data_i,
  output logic              ic_rtrn_vld_o,
  output logic              dc_rtrn_vld_o,
  output logic [TID_W-1:0]  rtrn_tid_o,
  output logic [RTRN_W-1:0] rtrn_data_o,
  output logic [3:0]        ic_outst_o,
  output logic [3:0]        dc_outst_o,
  output logic              idle_o,
  output logic              err_o
);

  typedef enum logic {IDLE, PRESENT} state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_e             state_q, state_d;
  logic               src_q, src_d;
  logic               rsp_exp_q, rsp_exp_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic [REQ_W-1:0]   data_q, data_d;
  logic               rr_q, rr_d;
  logic [3:0]         ic_cnt_q, ic_cnt_d;
  logic [3:0]         dc_cnt_q, dc_cnt_d;
  logic               idle_q;
  logic               err_q, err_d;

  logic               ic_elig, dc_elig, sel_dc, grant;
  logic               ic_inc, ic_dec, dc_inc, dc_dec;

  // Writes without a response never consume a credit, so they bypass the limit.
  assign ic_elig = ic_req_i && (!ic_rsp_exp_i || (ic_cnt_q < MAX_CNT));
  assign dc_elig = dc_req_i && (!dc_rsp_exp_i || (dc_cnt_q < MAX_CNT));
  assign sel_dc  = dc_elig && (!ic_elig || rr_q);
  assign grant   = (state_q == PRESENT) && mem_gnt_i;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    rsp_exp_d = rsp_exp_q;
    tid_d     = tid_q;
    data_d    = data_q;
    rr_d      = rr_q;
    case (state_q)
      IDLE: begin
        if (ic_elig || dc_elig) begin
          src_d     = sel_dc;
          rsp_exp_d = sel_dc ? dc_rsp_exp_i : ic_rsp_exp_i;
          tid_d     = sel_dc ? dc_tid_i     : ic_tid_i;
          data_d    = sel_dc ? dc_data_i    : ic_data_i;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (mem_gnt_i) begin
          rr_d    = ~src_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ic_inc = grant && !src_q && rsp_exp_q;
  assign dc_inc = grant &&  src_q && rsp_exp_q;
  assign ic_dec = mem_rtrn_vld_i && !mem_rtrn_src_i;
  assign dc_dec = mem_rtrn_vld_i &&  mem_rtrn_src_i;

  // A return against an empty counter is a protocol error; the counter saturates at zero.
  always_comb begin
    ic_cnt_d = ic_cnt_q;
    dc_cnt_d = dc_cnt_q;
    err_d    = err_q;
    if ((state_q == PRESENT) && (src_q ? !dc_req_i : !ic_req_i)) begin
      err_d = 1'b1;
    end
    if (ic_inc && !ic_dec) begin
      ic_cnt_d = ic_cnt_q + 4'd1;
    end else if (!ic_inc && ic_dec) begin
      if (ic_cnt_q == 4'd0) err_d = 1'b1;
      else                  ic_cnt_d = ic_cnt_q - 4'd1;
    end
    if (dc_inc && !dc_dec) begin
      dc_cnt_d = dc_cnt_q + 4'd1;
    end else if (!dc_inc && dc_dec) begin
      if (dc_cnt_q == 4'd0) err_d = 1'b1;
      else                  dc_cnt_d = dc_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      src_q     <= 1'b0;
      rsp_exp_q <= 1'b0;
      tid_q     <= '0;
      data_q    <= '0;
      rr_q      <= 1'b0;
      ic_cnt_q  <= 4'd0;
      dc_cnt_q  <= 4'd0;
      idle_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      rsp_exp_q <= rsp_exp_d;
      tid_q     <= tid_d;
      data_q    <= data_d;
      rr_q      <= rr_d;
      ic_cnt_q  <= ic_cnt_d;
      dc_cnt_q  <= dc_cnt_d;
      idle_q    <= (state_q == IDLE) && (ic_cnt_q == 4'd0) && (dc_cnt_q == 4'd0);
      err_q     <= err_d;
    end
  end

  assign mem_req_o  = (state_q == PRESENT);
  assign mem_src_o  = src_q;
  assign mem_tid_o  = tid_q;
  assign mem_data_o = data_q;
  assign ic_ack_o   = grant && !src_q;
  assign dc_ack_o   = grant &&  src_q;

  assign ic_rtrn_vld_o = mem_rtrn_vld_i && !mem_rtrn_src_i;
  assign dc_rtrn_vld_o = mem_rtrn_vld_i &&  mem_rtrn_src_i;
  assign rtrn_tid_o    = mem_rtrn_tid_i;
  assign rtrn_data_o   = mem_rtrn_data_i;

  assign ic_outst_o = ic_cnt_q;
  assign dc_outst_o = dc_cnt_q;
  assign idle_o     = idle_q;
  assign err_o      = err_q;

endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
- Shares one memory request/return channel between the instruction-cache miss path and the data-cache miss/write path.
- Round-robin arbitration on the request side; the selection is held stable until the memory side grants.
- Tracks outstanding response-expecting transactions per requester and applies a credit limit.
- Routes each return to its requester by source bit; flags protocol violations with a sticky error.

Parameters:
- REQ_W, 128, request payload width (address, size, data, type; opaque to this block)
- RTRN_W, 160, return payload width (opaque)
- TID_W, 2, transaction ID width carried with requests and returns
- MAX_OUTST, 4, maximum outstanding response-expecting transactions per requester (1..15)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- ic_req_i  in  1  icache request valid; held until ic_ack_o
- ic_rsp_exp_i  in  1  icache request expects a return
- ic_tid_i  in  TID_W  icache transaction ID
- ic_data_i  in  REQ_W  icache request payload
- ic_ack_o  out  1  one-cycle acceptance of the icache request
- dc_req_i, dc_rsp_exp_i, dc_tid_i, dc_data_i, dc_ack_o  as icache, for the dcache
- mem_req_o  out  1  request valid towards memory adapter
- mem_src_o  out  1  source of presented request: 0 = icache, 1 = dcache
- mem_tid_o  out  TID_W  transaction ID of presented request
- mem_data_o  out  REQ_W  presented payload
- mem_gnt_i  in  1  adapter accepts presented request this cycle
- mem_rtrn_vld_i  in  1  return valid
- mem_rtrn_src_i  in  1  return destination
- mem_rtrn_tid_i  in  TID_W  return transaction ID
- mem_rtrn_data_i  in  RTRN_W  return payload
- ic_rtrn_vld_o, dc_rtrn_vld_o  out  1  return strobe to the requester
- rtrn_tid_o  out  TID_W  shared return ID
- rtrn_data_o  out  RTRN_W  shared return payload
- ic_outst_o, dc_outst_o  out  4  outstanding counts
- idle_o  out  1  no request presented and both counts zero
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: mem_req_o=0, mem_src_o=0, mem_tid_o=0, mem_data_o=0, ic_ack_o=dc_ack_o=0, counts=0, RR pointer favours icache, err_o=0, idle_o=1. All return outputs are 0.
- FSM has two states:
  - IDLE: eligible = req_i && (!rsp_exp_i || outst < MAX_OUTST). If exactly one source is eligible, select it. If both are eligible, select the one the RR pointer favours. Register the source, tid and payload into the output register, set mem_req_o=1 next cycle, and go to PRESENT. No eligible source: stay in IDLE.
  - PRESENT: outputs stay constant while mem_gnt_i=0. When mem_gnt_i=1, pulse the selected source's ack for that same cycle (combinational from mem_gnt_i and the registered source), drop mem_req_o next cycle, and point the RR pointer at the other source. Return to IDLE, so at most one request per 2 cycles.
- Requesters must hold req/data stable until ack. A requester dropping req before ack sets err_o; the presented request is still completed.
- Counters:
  - Increment on grant when the registered rsp_exp is 1.
  - Decrement on a return for that source.
  - Grant and return in the same cycle on the same source: net unchanged.
  - A return to a source whose count is 0 sets err_o; the count stays 0 (no underflow) and the strobe is still forwarded.
- Credit: a source at MAX_OUTST with rsp_exp=1 is ineligible. A request with rsp_exp=0 (e.g. a write without ack) bypasses the credit check.
- Returns: combinational pass-through, zero latency. ic_rtrn_vld_o = mem_rtrn_vld_i & ~mem_rtrn_src_i; dc_rtrn_vld_o = mem_rtrn_vld_i & mem_rtrn_src_i. rtrn_tid_o and rtrn_data_o are forwarded unconditionally.
- idle_o is registered: it reflects state==IDLE and both counts zero, as of the previous edge.
- err_o clears only on reset.
- Reset mid-PRESENT abandons the request immediately; the adapter must also be reset.

Test Plan:
- Single icache request, rsp_exp=1, tid=0, data=0xA5: mem_req_o rises 1 cycle later. Hold mem_gnt_i=0 for 3 cycles → outputs constant. Grant → ic_ack_o pulses once, ic_outst_o=1, idle_o=0. Return with src=0 → ic_rtrn_vld_o=1, count 0, idle_o=1 one cycle later.
- Both requests held continuously, immediate grants → grant order I,D,I,D; each ack is a single cycle.
- dcache issues 4 rsp_exp requests with no returns (MAX_OUTST=4) → 5th rsp_exp request is blocked, icache is still served. One dcache return → the blocked request is presented within 2 cycles.
- dcache at MAX_OUTST issues a write with rsp_exp=0 → granted, dc_outst_o stays 4.
- dc_outst_o=1, dcache grant (rsp_exp=1) and dcache return in the same cycle → dc_outst_o stays 1.
- Return with src=0 while ic_outst_o=0 → err_o=1 and stays 1; ic_rtrn_vld_o still pulses. Assert rst_i mid-PRESENT → mem_req_o=0 and err_o=0 asynchronously.
